// File: rtl/mem_write_arbiter_pkg.sv
// Shared types and helpers for the memory write arbiter and the Memory
// read-side address stage.
//   arb_state_e : loader session state (IDLE / ACCEPT / DRAIN)
//   addr_is_io  : I/O range decode, address 0 is never I/O
package mem_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

  // True when addr lies in [base, base+count); subtract first so base+count
  // cannot wrap.
  function automatic logic addr_is_io(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] count);
    return (addr != 32'd0) && (count != 32'd0) && (addr >= base) &&
           ((addr - base) < count);
  endfunction

endpackage

// File: rtl/mem_write_fifo2.sv
// Two-entry FIFO holding loader writes until the core leaves a free cycle.
//   clock, reset     : clock, synchronous active-high reset
//   push, push_data  : write one entry (ignored when full and not popping)
//   pop              : drop the head entry (ignored when empty)
//   head             : registered head entry
//   full, empty      : occupancy flags, both derived from the count register
module mem_write_fifo2 #(
  parameter int unsigned WIDTH = 46
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem0_q, mem0_d;
  logic [WIDTH-1:0] mem1_q, mem1_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // mem0 is always the head; a pop shifts mem1 forward.
  always_comb begin : fifo_next_c
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) mem0_d = push_data;
        else                 mem1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          mem0_d = push_data;
        end else begin
          mem0_d = mem1_q;
          mem1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin : fifo_regs
    if (reset) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head  = mem0_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/mem_write_arbiter.sv
// Shares the Memory write port between the core (absolute priority, never
// stalled) and a valid/ready loader stream buffered in a 2-entry FIFO.
//   clock, reset            : clock, synchronous active-high reset
//   core_write_*            : core write request, always granted
//   loader_enable           : opens a session; deassertion drains and closes it
//   loader_valid/ready/addr/data : loader handshake and payload
//   write_*                 : registered Memory write port, incl. early I/O flag
//   loader_busy             : session open or draining
//   loader_write_count      : loader words issued this session (saturating)
//   loader_starved          : sticky, FIFO held full by the core too long
module mem_write_arbiter
  import mem_write_arbiter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH        = 36,
  parameter int unsigned ADDR_WIDTH        = 10,
  parameter int unsigned IO_PORT_BASE_ADDR = 0,
  parameter int unsigned IO_PORT_COUNT     = 0,
  parameter int unsigned STARVE_LIMIT      = 64,
  parameter int unsigned COUNT_WIDTH       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   core_write_enable,
  input  logic [ADDR_WIDTH-1:0]  core_write_addr,
  input  logic [WORD_WIDTH-1:0]  core_write_data,
  input  logic                   loader_enable,
  input  logic                   loader_valid,
  output logic                   loader_ready,
  input  logic [ADDR_WIDTH-1:0]  loader_addr,
  input  logic [WORD_WIDTH-1:0]  loader_data,
  output logic                   write_enable,
  output logic [ADDR_WIDTH-1:0]  write_addr,
  output logic                   write_addr_is_IO,
  output logic [WORD_WIDTH-1:0]  write_data,
  output logic                   loader_busy,
  output logic [COUNT_WIDTH-1:0] loader_write_count,
  output logic                   loader_starved
);

  localparam int unsigned FIFO_W   = ADDR_WIDTH + WORD_WIDTH;
  localparam int unsigned STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_e             state_q, state_d;
  logic                   write_enable_q, write_enable_d;
  logic [ADDR_WIDTH-1:0]  write_addr_q, write_addr_d;
  logic [WORD_WIDTH-1:0]  write_data_q, write_data_d;
  logic                   write_is_io_q, write_is_io_d;
  logic                   loader_busy_q, loader_busy_d;
  logic [COUNT_WIDTH-1:0] write_count_q, write_count_d;
  logic                   starved_q, starved_d;
  logic [STARVE_W-1:0]    starve_cnt_q, starve_cnt_d;

  logic                   accept_open, session_start;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0]      fifo_head;

  mem_write_fifo2 #(.WIDTH(FIFO_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({loader_addr, loader_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Session next state; re-enabling while draining resumes the same session.
  always_comb begin : fsm_next_c
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (loader_enable) state_d = ST_ACCEPT;
      ST_ACCEPT: if (!loader_enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (loader_enable)   state_d = ST_ACCEPT;
        else if (fifo_empty) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Session-level outputs.
  always_comb begin : fsm_out_c
    accept_open   = (state_q == ST_ACCEPT);
    session_start = (state_q == ST_IDLE) && loader_enable;
    loader_busy_d = (state_d != ST_IDLE);
  end

  assign loader_ready = accept_open && !fifo_full;
  assign fifo_push    = loader_valid && loader_ready;

  // Write-port grant; an idle cycle holds address/data so the I/O flag holds too.
  always_comb begin : grant_c
    write_enable_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    fifo_pop       = 1'b0;
    if (core_write_enable) begin
      write_enable_d = 1'b1;
      write_addr_d   = core_write_addr;
      write_data_d   = core_write_data;
    end else if (!fifo_empty) begin
      write_enable_d = 1'b1;
      write_addr_d   = fifo_head[FIFO_W-1 -: ADDR_WIDTH];
      write_data_d   = fifo_head[WORD_WIDTH-1:0];
      fifo_pop       = 1'b1;
    end
    write_is_io_d = addr_is_io(32'(write_addr_d), 32'(IO_PORT_BASE_ADDR),
                               32'(IO_PORT_COUNT));
  end

  // Per-session statistics: issued-word count and starvation tracking.
  always_comb begin : session_stats_c
    write_count_d = write_count_q;
    if (session_start) begin
      write_count_d = '0;
    end else if (fifo_pop && (write_count_q != '1)) begin
      write_count_d = write_count_q + COUNT_WIDTH'(1);
    end

    starve_cnt_d = '0;
    if (fifo_full && core_write_enable) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_W'(STARVE_LIMIT)) ? starve_cnt_q
                                                              : starve_cnt_q + STARVE_W'(1);
    end

    starved_d = !session_start &&
                (starved_q || (starve_cnt_d >= STARVE_W'(STARVE_LIMIT)));
  end

  always_ff @(posedge clock) begin : arb_regs
    if (reset) begin
      state_q        <= ST_IDLE;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      write_is_io_q  <= 1'b0;
      loader_busy_q  <= 1'b0;
      write_count_q  <= '0;
      starved_q      <= 1'b0;
      starve_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      write_is_io_q  <= write_is_io_d;
      loader_busy_q  <= loader_busy_d;
      write_count_q  <= write_count_d;
      starved_q      <= starved_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end

  assign write_enable       = write_enable_q;
  assign write_addr         = write_addr_q;
  assign write_data         = write_data_q;
  assign write_addr_is_IO   = write_is_io_q;
  assign loader_busy        = loader_busy_q;
  assign loader_write_count = write_count_q;
  assign loader_starved     = starved_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Scoreboard bench for mem_write_arbiter (BASE=8, COUNT=4, STARVE_LIMIT=4).
module tb_mem_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_write_enable;
  logic [9:0]  core_write_addr;
  logic [35:0] core_write_data;
  logic        loader_enable;
  logic        loader_valid;
  logic        loader_ready;
  logic [9:0]  loader_addr;
  logic [35:0] loader_data;
  logic        write_enable;
  logic [9:0]  write_addr;
  logic        write_addr_is_IO;
  logic [35:0] write_data;
  logic        loader_busy;
  logic [15:0] loader_write_count;
  logic        loader_starved;

  typedef struct packed {
    logic [9:0]  addr;
    logic [35:0] data;
    logic        io;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  mem_write_arbiter #(
    .WORD_WIDTH(36), .ADDR_WIDTH(10), .IO_PORT_BASE_ADDR(8),
    .IO_PORT_COUNT(4), .STARVE_LIMIT(4), .COUNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset),
    .core_write_enable(core_write_enable), .core_write_addr(core_write_addr),
    .core_write_data(core_write_data),
    .loader_enable(loader_enable), .loader_valid(loader_valid),
    .loader_ready(loader_ready), .loader_addr(loader_addr),
    .loader_data(loader_data),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_addr_is_IO(write_addr_is_IO), .write_data(write_data),
    .loader_busy(loader_busy), .loader_write_count(loader_write_count),
    .loader_starved(loader_starved)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic core_cycle(input logic [9:0] a, input logic [35:0] d, input logic io);
    core_write_enable = 1'b1;
    core_write_addr   = a;
    core_write_data   = d;
    exp_q.push_back(exp_t'({a, d, io}));
    tick();
  endtask

  task automatic expect_write(input logic [9:0] a, input logic [35:0] d, input logic io);
    exp_q.push_back(exp_t'({a, d, io}));
  endtask

  // Offer one loader word and wait (bounded) for the handshake edge.
  task automatic loader_send(input logic [9:0] a, input logic [35:0] d);
    int budget = 0;
    loader_valid = 1'b1;
    loader_addr  = a;
    loader_data  = d;
    while (!loader_ready && budget < 20) begin
      tick();
      budget++;
    end
    check("loader_ready_wait", 64'(loader_ready), 64'(1));
    tick();
  endtask

  // Monitor: every issued write must match the head of the expected queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   write_addr, write_data);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 64'(write_addr), 64'(e.addr));
          check("write_data", 64'(write_data), 64'(e.data));
          check("write_addr_is_IO", 64'(write_addr_is_IO), 64'(e.io));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    core_write_enable = 1'b0; core_write_addr = '0; core_write_data = '0;
    loader_enable = 1'b0; loader_valid = 1'b0; loader_addr = '0; loader_data = '0;
    tick(); tick();
    check("rst_write_enable", 64'(write_enable), 64'(0));
    check("rst_write_addr", 64'(write_addr), 64'(0));
    check("rst_write_data", 64'(write_data), 64'(0));
    check("rst_is_io", 64'(write_addr_is_IO), 64'(0));
    check("rst_ready", 64'(loader_ready), 64'(0));
    check("rst_busy", 64'(loader_busy), 64'(0));
    check("rst_count", 64'(loader_write_count), 64'(0));
    check("rst_starved", 64'(loader_starved), 64'(0));
    reset = 1'b0;
    tick();

    // Core only.
    for (int i = 0; i < 3; i++) begin
      core_cycle(10'd5, 36'h123, 1'b0);
      check("core_only_ready", 64'(loader_ready), 64'(0));
    end
    core_write_enable = 1'b0;
    tick(); tick();

    // Idle core, 4 loader words to 10..13 (10, 11 fall in the I/O window).
    loader_enable = 1'b1;
    tick();
    check("session_busy", 64'(loader_busy), 64'(1));
    check("session_ready", 64'(loader_ready), 64'(1));
    expect_write(10'd10, 36'h100, 1'b1);
    expect_write(10'd11, 36'h101, 1'b1);
    expect_write(10'd12, 36'h102, 1'b0);
    expect_write(10'd13, 36'h103, 1'b0);
    loader_send(10'd10, 36'h100);
    loader_send(10'd11, 36'h101);
    loader_send(10'd12, 36'h102);
    loader_send(10'd13, 36'h103);
    loader_valid = 1'b0;
    tick(); tick(); tick();
    check("burst_count", 64'(loader_write_count), 64'(4));
    loader_enable = 1'b0;
    tick();
    check("drain_busy", 64'(loader_busy), 64'(1));
    check("drain_ready", 64'(loader_ready), 64'(0));
    tick();
    check("idle_busy", 64'(loader_busy), 64'(0));

    // Contention: core writes every cycle, loader offers 3 words.
    loader_enable = 1'b1;
    core_cycle(10'd20, 36'h200, 1'b0);
    check("count_cleared", 64'(loader_write_count), 64'(0));
    loader_valid = 1'b1; loader_addr = 10'd30; loader_data = 36'h300;
    core_cycle(10'd21, 36'h201, 1'b0);
    loader_addr = 10'd31; loader_data = 36'h301;
    core_cycle(10'd22, 36'h202, 1'b0);
    check("full_ready", 64'(loader_ready), 64'(0));
    loader_addr = 10'd32; loader_data = 36'h302;
    core_cycle(10'd23, 36'h203, 1'b0);
    check("full_ready_hold", 64'(loader_ready), 64'(0));
    core_cycle(10'd24, 36'h204, 1'b0);
    check("contention_count", 64'(loader_write_count), 64'(0));
    expect_write(10'd30, 36'h300, 1'b0);
    expect_write(10'd31, 36'h301, 1'b0);
    expect_write(10'd32, 36'h302, 1'b0);
    core_write_enable = 1'b0;
    tick();
    check("freed_ready", 64'(loader_ready), 64'(1));
    tick();
    loader_valid = 1'b0;
    tick(); tick();
    check("contention_count_done", 64'(loader_write_count), 64'(3));
    loader_enable = 1'b0;
    tick(); tick();
    check("contention_idle", 64'(loader_busy), 64'(0));

    // I/O decode at the window edges and address 0.
    core_cycle(10'd8, 36'h8, 1'b1);
    core_cycle(10'd11, 36'hb, 1'b1);
    core_cycle(10'd12, 36'hc, 1'b0);
    core_cycle(10'd0, 36'h0, 1'b0);
    core_write_enable = 1'b0;
    tick();

    // Starvation: FIFO full while the core writes for 4 cycles.
    loader_enable = 1'b1;
    core_cycle(10'd40, 36'h400, 1'b0);
    loader_valid = 1'b1; loader_addr = 10'd50; loader_data = 36'h500;
    core_cycle(10'd41, 36'h401, 1'b0);
    loader_addr = 10'd51; loader_data = 36'h501;
    core_cycle(10'd42, 36'h402, 1'b0);
    loader_valid = 1'b0;
    core_cycle(10'd43, 36'h403, 1'b0);
    core_cycle(10'd44, 36'h404, 1'b0);
    core_cycle(10'd45, 36'h405, 1'b0);
    check("starved_before_limit", 64'(loader_starved), 64'(0));
    core_cycle(10'd46, 36'h406, 1'b0);
    check("starved_at_limit", 64'(loader_starved), 64'(1));
    expect_write(10'd50, 36'h500, 1'b0);
    expect_write(10'd51, 36'h501, 1'b0);
    core_write_enable = 1'b0;
    loader_enable = 1'b0;
    tick();
    check("starve_drain_busy", 64'(loader_busy), 64'(1));
    check("starved_in_drain", 64'(loader_starved), 64'(1));
    tick(); tick();
    check("starve_idle_busy", 64'(loader_busy), 64'(0));
    check("starved_sticky_idle", 64'(loader_starved), 64'(1));
    check("starve_count", 64'(loader_write_count), 64'(2));
    loader_enable = 1'b1;
    tick();
    check("starved_cleared", 64'(loader_starved), 64'(0));
    check("new_session_count", 64'(loader_write_count), 64'(0));

    // Reset mid-session with 2 words queued; they must never be written.
    loader_valid = 1'b1; loader_addr = 10'd60; loader_data = 36'h600;
    core_cycle(10'd70, 36'h700, 1'b0);
    loader_addr = 10'd61; loader_data = 36'h601;
    core_cycle(10'd71, 36'h701, 1'b0);
    check("pre_reset_full", 64'(loader_ready), 64'(0));
    loader_valid = 1'b0;
    core_write_enable = 1'b0;
    loader_enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_write_enable", 64'(write_enable), 64'(0));
    check("mid_rst_write_addr", 64'(write_addr), 64'(0));
    check("mid_rst_write_data", 64'(write_data), 64'(0));
    check("mid_rst_is_io", 64'(write_addr_is_IO), 64'(0));
    check("mid_rst_ready", 64'(loader_ready), 64'(0));
    check("mid_rst_busy", 64'(loader_busy), 64'(0));
    check("mid_rst_count", 64'(loader_write_count), 64'(0));
    check("mid_rst_starved", 64'(loader_starved), 64'(0));
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_busy", 64'(loader_busy), 64'(0));

    check("expected_queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_arbiter.md
Name: mem_write_arbiter

Overview:
Shares the single write port of the on-chip Memory block between two sources: the core pipeline, which always has priority and never stalls, and an external loader stream using a valid/ready handshake. Loader writes are held in a 2-entry FIFO and issued only in cycles where the core is not writing. The block sits immediately in front of the Memory write port. It also generates the write_addr_is_IO flag that Memory requires one stage early.

Parameters:
WORD_WIDTH, 36, data word width
ADDR_WIDTH, 10, memory address width
IO_PORT_BASE_ADDR, 0, first I/O port address; must be nonzero when IO_PORT_COUNT > 0
IO_PORT_COUNT, 0, number of I/O ports mapped at the base address
STARVE_LIMIT, 64, consecutive cycles with a full FIFO before loader_starved asserts
COUNT_WIDTH, 16, width of loader_write_count

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
core_write_enable  in  1  core write request; always granted
core_write_addr  in  ADDR_WIDTH  core write address
core_write_data  in  WORD_WIDTH  core write data
loader_enable  in  1  opens the loader session; deassertion drains and closes it
loader_valid  in  1  loader word present
loader_ready  out  1  loader word accepted when valid && ready
loader_addr  in  ADDR_WIDTH  loader write address
loader_data  in  WORD_WIDTH  loader write data
write_enable  out  1  to Memory write_enable
write_addr  out  ADDR_WIDTH  to Memory write_addr
write_addr_is_IO  out  1  high when write_addr lies in [BASE, BASE+IO_PORT_COUNT)
write_data  out  WORD_WIDTH  to Memory write_data
loader_busy  out  1  high in ACCEPT or DRAIN
loader_write_count  out  COUNT_WIDTH  loader words issued in this session
loader_starved  out  1  sticky starvation flag for the current session

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; starve counter 0.
- Outputs are registered. A grant in cycle N appears on write_* in cycle N+1.
- Grant rule:
  - core_write_enable=1: the core is issued and the FIFO head is held.
  - Otherwise, FIFO non-empty: the FIFO head is issued and popped.
  - Otherwise: write_enable=0, and the address/data outputs hold their last values.
- write_addr_is_IO is decoded from the granted address combinationally and registered together with it.
  - Address 0 is never an I/O address.
  - A write to address 0 is still issued; Memory discards it.
- FIFO: 2 entries.
  - loader_ready = (state==ACCEPT) && !full.
  - Push occurs on the valid&&ready edge.
  - Push and pop in the same cycle are legal: occupancy is unchanged and order is preserved.
  - A push into an empty FIFO is not issued in the same cycle; the word is issued no earlier than the next cycle.
- State machine:
  - IDLE: loader_ready=0. loader_enable=1 -> ACCEPT, clearing loader_write_count and loader_starved.
  - ACCEPT: accepts words. loader_enable=0 -> DRAIN.
  - DRAIN: loader_ready=0. FIFO empty -> IDLE. loader_enable re-asserted in DRAIN -> ACCEPT without clearing the count.
- loader_write_count increments once per issued loader word and saturates at all-ones.
- Starvation:
  - The starve counter increments each cycle the FIFO is full and the core is writing; it resets otherwise.
  - Reaching STARVE_LIMIT sets loader_starved, which stays set until the next IDLE->ACCEPT.
  - The core is never stalled.
- Reset mid-session: the FIFO is flushed and pending loader words are lost. loader_ready drops in the cycle after reset is sampled. No write is issued during that cycle.
- loader_valid without ready: the loader must hold addr and data stable. The arbiter places no requirement on valid persistence.

Decomposition:
- Shared package holds:
  - state encoding IDLE/ACCEPT/DRAIN (2 bits)
  - the I/O range decode function (addr, base, count) -> is_IO, reused by the Memory read-side address stage
- One sub-module, mem_write_fifo2: 2-entry FIFO with push/pop/full/empty and a registered head output.

Test Plan:
- Core only: core writes addr 5 data 0x123 for 3 cycles with loader_enable=0 -> write_enable=1, addr 5, data 0x123 one cycle later each cycle; loader_ready=0.
- Idle core: enable the loader, send 4 words to addr 10..13 back-to-back -> writes issued in order, 1-cycle spacing after first acceptance; count=4; after enable drop, DRAIN then IDLE, busy=0.
- Contention: core writes every cycle while the loader sends 3 words -> 2 accepted, ready=0; core uninterrupted. When the core idles 2 cycles, both queued words are issued in order and the third is accepted.
- I/O decode with BASE=8, COUNT=4: writes to addr 8, 11, 12, 0 -> write_addr_is_IO = 1, 1, 0, 0.
- Starvation with STARVE_LIMIT=4: FIFO full and core busy 4 cycles -> loader_starved=1 in the following cycle. It stays set through DRAIN and clears on the next session start.
- Reset mid-session with 2 words queued: assert reset 1 cycle -> FIFO empty, no loader writes afterwards, all outputs 0, state IDLE.
